// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan controller: FSM state encoding.
package mux_scan_ctrl_pkg;

  // 2'd3 is unused and recovers to IDLE in the next-state logic.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Bus between the scan controller, the mux it drives and the result consumer.
// master: the controller side. slave: the mux/consumer side.
interface mux_scan_ctrl_if #(
  parameter int SEL_W = 2
);
  localparam int NUM = 2 ** SEL_W;

  logic             start;
  logic             mux_out;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic [NUM-1:0]   result;
  logic             result_valid;
  logic             result_ready;

  modport master (
    input  start, mux_out, result_ready,
    output sel, busy, result, result_valid
  );

  modport slave (
    output start, mux_out, result_ready,
    input  sel, busy, result, result_valid
  );
endinterface

// File: rtl/mux_2to4.sv
// 4:1 select mux whose output is scanned by the controller.
module mux_2to4 (
  input  logic [3:0] data,
  input  logic [1:0] sel,
  output logic       out
);
  assign out = data[sel];
endmodule

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// Dwell counter: counts cycles spent on one select index and flags the
// last one so the controller knows when to sample the mux output.
module dwell_timer #(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] TC_VAL = CW'(DWELL - 1);

  generate
    if (DWELL < 1) begin : g_bad_dwell
      $error("dwell_timer: DWELL must be >= 1");
    end
  endgenerate

  logic [CW-1:0] cnt_reg;

  assign tc = (cnt_reg == TC_VAL);

  // Count while enabled, wrapping to 0 on the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tc ? '0 : cnt_reg + CW'(1);
    end
  end
endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller: walks sel through every mux index, samples the mux
// output once per index after DWELL cycles, and offers the assembled word
// to a consumer over valid/ready.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int DWELL = 1
) (
  input  logic           clk,
  input  logic           rst,
  mux_scan_ctrl_if.master bus
);
  localparam int NUM = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM - 1);

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic [NUM-1:0]   result_reg, result_next;
  logic             tmr_clr, tmr_en, tmr_tc;

  dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tmr_tc)
  );

  // State, select and result registers; reset aborts any scan at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      sel_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      result_reg <= result_next;
    end
  end

  // Next-state logic: capture one bit per index on the dwell terminal count.
  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    result_next = result_reg;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        tmr_clr = 1'b1;
        if (bus.start) begin
          state_next = SCAN;
          sel_next   = '0;
        end
      end
      SCAN: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          result_next[sel_reg] = bus.mux_out;
          sel_next             = sel_reg + SEL_W'(1);
          if (sel_reg == LAST_SEL) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        // Start is deliberately not looked at here; a new scan needs IDLE.
        if (bus.result_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        sel_next   = '0;
        tmr_clr    = 1'b1;
      end
    endcase
  end

  assign bus.sel          = sel_reg;
  assign bus.result       = result_reg;
  assign bus.busy         = (state_reg == SCAN) || (state_reg == DONE);
  assign bus.result_valid = (state_reg == DONE);
endmodule
